spi_reg_controller: RTL and testbench

//  Byte-level command sequencer sitting between the SPI byte slave and the FPGA register bus.

---
 rtl/spi_reg_controller_pkg.sv | 23 ++
 rtl/spi_reg_controller_if.sv | 23 ++
 rtl/spi_reg_controller_sync2.sv | 20 ++
 rtl/spi_reg_controller.sv | 125 ++++++++++++
 tb/tb_spi_reg_controller.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_controller_pkg.sv
// rtl/spi_reg_controller_pkg.sv - shared constants, state encoding and status packing
package spi_reg_controller_pkg;

  localparam int CMD_RD_BIT   = 7;
  localparam int FL_OVERRUN   = 0;
  localparam int FL_RD_LATE   = 1;
  localparam int FL_ADDR_WRAP = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_HOLD,
    ST_WR_DATA,
    ST_WR_REQ
  } state_t;

  function automatic logic [7:0] status_byte(input logic [3:0] id, input logic [2:0] flags);
    return {id, 1'b0, flags};
  endfunction

endpackage

// File: rtl/spi_reg_controller_if.sv
// rtl/spi_reg_controller_if.sv - req/ack register bus between the sequencer and the register file
interface spi_reg_controller_if #(
  parameter int ADDR_W = 7
);

  logic              reg_req;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;
  logic              reg_ack;

  modport master (
    output reg_req, reg_we, reg_addr, reg_wdata,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_req, reg_we, reg_addr, reg_wdata,
    output reg_rdata, reg_ack
  );

endinterface

// File: rtl/spi_reg_controller_sync2.sv
// rtl/spi_reg_controller_sync2.sv - two-flop synchronizer for the asynchronous slave select
module spi_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{RST_VAL}};
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/spi_reg_controller.sv
// rtl/spi_reg_controller.sv - SPI byte-stream command sequencer driving the register bus
// Byte 0 in is the command, byte 0 out is the status; later bytes stream auto-incrementing accesses.
module spi_reg_controller
  import spi_reg_controller_pkg::*;
#(
  parameter int         ADDR_W    = 7,
  parameter logic [3:0] STATUS_ID = 4'hA
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ssel_n_i,
  input  logic                        rx_done_i,
  input  logic [7:0]                  rx_byte_i,
  output logic [7:0]                  tx_byte_o,
  output logic                        busy_o,
  spi_reg_controller_if.master        bus
);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        tx_q;
  logic              req_q;
  logic              we_q;
  logic [2:0]        flags_q;
  logic [2:0]        flags_d;
  logic              ssel_n_s;
  logic              sel;
  logic              ack_v;

  spi_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ssel_n_i),
    .q_o   (ssel_n_s)
  );

  assign sel   = ~ssel_n_s;
  assign ack_v = bus.reg_ack & req_q;

  // Flags clear on the status snapshot, but an event in that same cycle survives.
  always_comb begin
    flags_d = (state_q == ST_IDLE && sel) ? 3'b000 : flags_q;
    if (ack_v && (&addr_q))
      flags_d[FL_ADDR_WRAP] = 1'b1;
    if (rx_done_i && (state_q == ST_RD_REQ || state_q == ST_RD_WAIT))
      flags_d[FL_RD_LATE] = 1'b1;
    if (rx_done_i && state_q == ST_WR_REQ)
      flags_d[FL_OVERRUN] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      tx_q    <= {STATUS_ID, 4'h0};
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
      if (ack_v) addr_q <= addr_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (sel) begin
            tx_q    <= status_byte(STATUS_ID, flags_q);
            state_q <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (rx_done_i) begin
            addr_q  <= rx_byte_i[ADDR_W-1:0];
            state_q <= rx_byte_i[CMD_RD_BIT] ? ST_RD_REQ : ST_WR_DATA;
          end else if (!sel) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          req_q   <= 1'b1;
          we_q    <= 1'b0;
          state_q <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (ack_v) begin
            req_q   <= 1'b0;
            tx_q    <= bus.reg_rdata;
            state_q <= sel ? ST_RD_HOLD : ST_IDLE;
          end
        end
        ST_RD_HOLD: begin
          if (rx_done_i)  state_q <= ST_RD_REQ;
          else if (!sel)  state_q <= ST_IDLE;
        end
        ST_WR_DATA: begin
          if (rx_done_i) begin
            wdata_q <= rx_byte_i;
            state_q <= ST_WR_REQ;
          end else if (!sel) begin
            state_q <= ST_IDLE;
          end
        end
        ST_WR_REQ: begin
          // A late byte here is the overrun case: flagged above, otherwise dropped.
          if (ack_v) begin
            req_q   <= 1'b0;
            state_q <= sel ? ST_WR_DATA : ST_IDLE;
          end else begin
            req_q <= 1'b1;
            we_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_byte_o     = tx_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign bus.reg_req   = req_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// tb/tb_spi_reg_controller.sv - self-checking bench for spi_reg_controller
module tb_spi_reg_controller;

  logic       clk;
  logic       rst_n;
  logic       ssel_n;
  logic       rx_done;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       busy;

  spi_reg_controller_if #(.ADDR_W(7)) bus ();

  spi_reg_controller #(.ADDR_W(7), .STATUS_ID(4'hA)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ssel_n_i  (ssel_n),
    .rx_done_i (rx_done),
    .rx_byte_i (rx_byte),
    .tx_byte_o (tx_byte),
    .busy_o    (busy),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    logic [7:0] cmd;
    int         n;
    logic [7:0] d [3];
    logic [7:0] status;
  } vec_t;

  txn_t exp_q[$];
  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ack_dly = 2;
  bit   hold_ack = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Register-bus slave: every request is matched against the expected-transaction queue.
  initial begin
    txn_t t;
    bus.reg_ack   = 1'b0;
    bus.reg_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && bus.reg_req && !hold_ack) begin
        repeat (ack_dly - 1) @(negedge clk);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: got we=%b addr=%h, expected no request",
                   bus.reg_we, bus.reg_addr);
          bus.reg_rdata = 8'h00;
        end else begin
          t = exp_q.pop_front();
          check("req_we", 8'(bus.reg_we), 8'(t.we));
          check("req_addr", 8'(bus.reg_addr), 8'(t.addr));
          if (t.we) check("req_wdata", bus.reg_wdata, t.data);
          bus.reg_rdata = t.we ? 8'h00 : t.data;
        end
        bus.reg_ack = 1'b1;
        @(negedge clk);
        bus.reg_ack = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check(name, 8'(busy), 8'h00);
  endtask

  task automatic open_msg(input string name, input logic [7:0] status);
    ssel_n = 1'b0;
    repeat (4) @(negedge clk);
    check(name, tx_byte, status);
  endtask

  task automatic close_msg(input string name);
    ssel_n = 1'b1;
    wait_idle(name);
    check({name, "_queue"}, 8'(exp_q.size()), 8'h00);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_msg(input vec_t v);
    logic [6:0] a  = v.cmd[6:0];
    bit         rd = v.cmd[7];
    ack_dly = rd ? 3 : 2;
    open_msg("status", v.status);
    if (rd) exp_q.push_back(txn_t'({1'b0, a, v.d[0]}));
    send_byte(v.cmd);
    repeat (12) @(negedge clk);
    for (int i = 0; i < v.n; i++) begin
      if (rd) begin
        check("rd_data", tx_byte, v.d[i]);
        exp_q.push_back(txn_t'({1'b0, 7'(a + 7'(i + 1)), v.d[i + 1]}));
      end else begin
        exp_q.push_back(txn_t'({1'b1, 7'(a + 7'(i)), v.d[i]}));
      end
      send_byte(rd ? 8'h00 : v.d[i]);
      repeat (12) @(negedge clk);
    end
    close_msg("end_idle");
  endtask

  initial begin
    vecs[0] = '{8'h05, 2, '{8'h11, 8'h22, 8'h00}, 8'hA0};
    vecs[1] = '{8'h83, 2, '{8'h5A, 8'hC3, 8'h96}, 8'hA0};
    vecs[2] = '{8'h7F, 2, '{8'h33, 8'h44, 8'h00}, 8'hA0};
    vecs[3] = '{8'h10, 0, '{8'h00, 8'h00, 8'h00}, 8'hA4};
    vecs[4] = '{8'hFF, 1, '{8'h12, 8'h34, 8'h00}, 8'hA0};
    vecs[5] = '{8'h81, 0, '{8'hE7, 8'h00, 8'h00}, 8'hA4};

    rst_n   = 1'b0;
    ssel_n  = 1'b1;
    rx_done = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_byte, 8'hA0);
    check("rst_req", 8'(bus.reg_req), 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_we", 8'(bus.reg_we), 8'h00);
    check("rst_addr", 8'(bus.reg_addr), 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[k]) run_msg(vecs[k]);

    // Overrun: second byte arrives while the write is still waiting for ack.
    ack_dly = 2;
    open_msg("ovr_status", 8'hA0);
    send_byte(8'h20);
    repeat (4) @(negedge clk);
    hold_ack = 1'b1;
    exp_q.push_back(txn_t'({1'b1, 7'h20, 8'h66}));
    send_byte(8'h66);
    repeat (3) @(negedge clk);
    check("ovr_req_up", 8'(bus.reg_req), 8'h01);
    send_byte(8'h77);
    @(negedge clk);
    check("ovr_wdata_kept", bus.reg_wdata, 8'h66);
    hold_ack = 1'b0;
    repeat (10) @(negedge clk);
    close_msg("ovr_idle");
    run_msg('{8'h00, 0, '{8'h00, 8'h00, 8'h00}, 8'hA1});

    // Late byte during the prefetch: stale status stays on MISO, read still completes.
    ack_dly = 3;
    open_msg("late_status", 8'hA0);
    exp_q.push_back(txn_t'({1'b0, 7'h20, 8'h3C}));
    send_byte(8'hA0);
    check("late_tx_stale", tx_byte, 8'hA0);
    send_byte(8'h00);
    repeat (12) @(negedge clk);
    check("late_tx_rd", tx_byte, 8'h3C);
    close_msg("late_idle");
    run_msg('{8'h00, 0, '{8'h00, 8'h00, 8'h00}, 8'hA2});

    // Deselect while a read is outstanding: request must be held until ack.
    ack_dly = 6;
    open_msg("abort_status", 8'hA0);
    exp_q.push_back(txn_t'({1'b0, 7'h10, 8'hAB}));
    send_byte(8'h90);
    @(negedge clk);
    ssel_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_req_held", 8'(bus.reg_req), 8'h01);
    wait_idle("abort_idle");
    check("abort_tx", tx_byte, 8'hAB);
    check("abort_req_low", 8'(bus.reg_req), 8'h00);
    check("abort_queue", 8'(exp_q.size()), 8'h00);
    repeat (3) @(negedge clk);

    // Data byte lands on the same cycle the synchronized select falls.
    ack_dly = 2;
    open_msg("edge_status", 8'hA0);
    send_byte(8'h40);
    repeat (4) @(negedge clk);
    exp_q.push_back(txn_t'({1'b1, 7'h40, 8'h99}));
    ssel_n = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h99);
    wait_idle("edge_idle");
    check("edge_queue", 8'(exp_q.size()), 8'h00);
    repeat (3) @(negedge clk);

    // Asynchronous reset with a write request pending.
    open_msg("rst_mid_status", 8'hA0);
    send_byte(8'h30);
    repeat (4) @(negedge clk);
    hold_ack = 1'b1;
    send_byte(8'hEE);
    repeat (3) @(negedge clk);
    check("rst_mid_req_before", 8'(bus.reg_req), 8'h01);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 8'(bus.reg_req), 8'h00);
    check("rst_mid_busy", 8'(busy), 8'h00);
    check("rst_mid_tx", tx_byte, 8'hA0);
    hold_ack = 1'b0;
    ssel_n   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_msg('{8'h01, 1, '{8'h5A, 8'h00, 8'h00}, 8'hA0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
